xbar_write_arbiter: RTL

XBAR_WRITE_ARBITER -- requirements
Module: xbar_write_arbiter

---
 rtl/xbar_arb_pkg.sv | 22 ++
 rtl/rr_picker.sv | 36 +++
 rtl/xbar_write_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/xbar_arb_pkg.sv
// Shared types and defaults for the crossbar write-port arbiter.
package xbar_arb_pkg;

  // Two-state packet arbiter: waiting for a request, or moving one packet.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 32;

  // Debug beat counter width and its saturation value.
  localparam int         BEAT_CNT_W   = 8;
  localparam logic [7:0] BEAT_CNT_MAX = 8'hFF;

  // Width of a requester index; never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid requester searching upward
// from (last_winner + 1), wrapping from NUM_REQ-1 back to 0.
module rr_picker
  import xbar_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = idx_width(NUM_REQ_DEF)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last_winner,
  output logic [NUM_REQ-1:0] pick,
  output logic               any_valid
);

  int              lw_int;
  logic [IDX_W-1:0] idx_v;
  logic            found;

  // Walk the rotated priority order once and keep the first hit only.
  always_comb begin
    pick   = '0;
    found  = 1'b0;
    idx_v  = '0;
    lw_int = int'(last_winner);
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_v = IDX_W'((lw_int + k) % NUM_REQ);
      if (!found && req_valid[idx_v]) begin
        pick[idx_v] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any_valid = |req_valid;

endmodule

// File: rtl/xbar_write_arbiter.sv
// Packet-locked round-robin arbiter that shares one FIFO write port among
// NUM_REQ requesters. The FIFO full flag back-pressures the owner only.
module xbar_write_arbiter
  import xbar_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      clk_tx,
  input  logic                      nrst_tx,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      full,
  output logic                      push,
  output logic [DATA_W-1:0]         push_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_t            state_reg, state_next;
  logic [NUM_REQ-1:0]    grant_reg, grant_next;
  logic [IDX_W-1:0]      last_winner_reg, last_winner_next;
  logic [BEAT_CNT_W-1:0] beat_cnt_reg, beat_cnt_next;

  logic [NUM_REQ-1:0]    pick;
  logic                  any_valid;
  logic [IDX_W-1:0]      grant_idx;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_W-1:0]     sel_data;
  logic [DATA_W-1:0]     masked_data [NUM_REQ];
  logic                  push_int;
  logic                  xfer_active;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req_valid   (req_valid),
    .last_winner (last_winner_reg),
    .pick        (pick),
    .any_valid   (any_valid)
  );

  // Per-requester data lanes masked by the one-hot grant, so the owner's
  // word can be recovered with a plain OR tree.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign masked_data[gi] = {DATA_W{grant_reg[gi]}} & req_data[gi*DATA_W +: DATA_W];
  end

  // Collapse the masked lanes into the owner's data word.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_data = sel_data | masked_data[i];
    end
  end

  // One-hot grant to binary index, remembered as last_winner at packet end.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_reg[i]) begin
        grant_idx = IDX_W'(i);
      end
    end
  end

  assign sel_valid = |(req_valid & grant_reg);
  assign sel_last  = |(req_last & grant_reg);

  // Next-state logic: arbitrate in IDLE, move beats in XFER until the
  // owner's last beat is actually written.
  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    last_winner_next = last_winner_reg;
    beat_cnt_next    = beat_cnt_reg;
    push_int         = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        if (any_valid) begin
          state_next    = ARB_XFER;
          grant_next    = pick;
          beat_cnt_next = '0;
        end
      end
      ARB_XFER: begin
        push_int = sel_valid & ~full;
        if (push_int) begin
          if (beat_cnt_reg != BEAT_CNT_MAX) begin
            beat_cnt_next = beat_cnt_reg + 8'd1;
          end
          if (sel_last) begin
            state_next       = ARB_IDLE;
            grant_next       = '0;
            last_winner_next = grant_idx;
          end
        end
      end
      default: begin
        state_next = ARB_IDLE;
        grant_next = '0;
      end
    endcase
  end

  // State registers; reset leaves requester 0 first in line.
  always_ff @(posedge clk_tx) begin
    if (!nrst_tx) begin
      state_reg       <= ARB_IDLE;
      grant_reg       <= '0;
      last_winner_reg <= IDX_W'(NUM_REQ - 1);
      beat_cnt_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      last_winner_reg <= last_winner_next;
      beat_cnt_reg    <= beat_cnt_next;
    end
  end

  // Handshake outputs are forced quiet while reset is held, so a packet
  // interrupted by reset cannot push one more beat in that cycle.
  assign xfer_active = nrst_tx & (state_reg == ARB_XFER);
  assign busy        = xfer_active;
  assign push        = nrst_tx & push_int;
  assign push_data   = push ? sel_data : '0;
  assign req_ready   = {NUM_REQ{xfer_active & ~full}} & grant_reg;
  assign grant       = grant_reg;

endmodule
